// File: rtl/misao_mem_arb_if.sv
//------------------------------------------------------------------------------
// Module   : misao_mem_arb_if
// Brief    : Requester handshakes plus nibble-memory bus of the arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface misao_mem_arb_if #(
    parameter int ADDR_W = 16
);
    logic              c_req;
    logic              d_req;
    logic              c_we;
    logic              d_we;
    logic [ADDR_W-1:0] c_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        c_len;
    logic [1:0]        d_len;
    logic [15:0]       c_wdata;
    logic [15:0]       d_wdata;
    logic              c_gnt;
    logic              d_gnt;
    logic              c_done;
    logic              d_done;
    logic [15:0]       rdata;
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_data_out;
    logic [3:0]        mem_data_in;

    // Arbiter side
    modport slave (
        input  c_req, d_req, c_we, d_we, c_addr, d_addr, c_len, d_len,
        input  c_wdata, d_wdata, mem_data_in,
        output c_gnt, d_gnt, c_done, d_done, rdata,
        output mem_en, mem_rw, mem_addr, mem_data_out
    );

    // Requesters and memory side
    modport master (
        output c_req, d_req, c_we, d_we, c_addr, d_addr, c_len, d_len,
        output c_wdata, d_wdata, mem_data_in,
        input  c_gnt, d_gnt, c_done, d_done, rdata,
        input  mem_en, mem_rw, mem_addr, mem_data_out
    );
endinterface

`default_nettype wire

// File: rtl/misao_mem_arb.sv
//------------------------------------------------------------------------------
// Module   : misao_mem_arb
// Brief    : Round-robin arbiter giving core/debug 1-4 nibble bursts on a memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module misao_mem_arb #(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    misao_mem_arb_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_RTAIL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_owner;     // 0 = core, 1 = debug
    logic              r_last_d;    // previous grant went to debug
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_last_k;
    logic [1:0]        r_k;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic              r_rd_pend;
    logic [1:0]        r_rd_idx;

    logic              w_any;
    logic              w_pick_d;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [1:0]        w_sel_len;
    logic [15:0]       w_sel_wdata;
    logic [3:0]        w_wnib;
    logic [ADDR_W-1:0] w_addr_k;

    function automatic logic [1:0] f_last_k(input logic [1:0] len);
        case (len)
            2'b01:   f_last_k = 2'd1;
            2'b10:   f_last_k = 2'd3;
            default: f_last_k = 2'd0;
        endcase
    endfunction

    // A lone request always wins; a tie goes to whoever was not served last.
    assign w_any       = bus.c_req | bus.d_req;
    assign w_pick_d    = bus.d_req & (~bus.c_req | ~r_last_d);
    assign w_sel_we    = w_pick_d ? bus.d_we    : bus.c_we;
    assign w_sel_addr  = w_pick_d ? bus.d_addr  : bus.c_addr;
    assign w_sel_len   = w_pick_d ? bus.d_len   : bus.c_len;
    assign w_sel_wdata = w_pick_d ? bus.d_wdata : bus.c_wdata;

    assign w_wnib   = r_wdata[{r_k, 2'b00} +: 4];
    assign w_addr_k = r_base + {{(ADDR_W-2){1'b0}}, r_k};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.mem_en       = 1'b0;
        bus.mem_rw       = 1'b1;
        bus.mem_addr     = '0;
        bus.mem_data_out = 4'h0;
        bus.c_gnt        = 1'b0;
        bus.d_gnt        = 1'b0;
        bus.c_done       = 1'b0;
        bus.d_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                bus.mem_en       = 1'b1;
                bus.mem_rw       = ~r_we;
                bus.mem_addr     = w_addr_k;
                bus.mem_data_out = r_we ? w_wnib : 4'h0;
                bus.c_gnt        = ~r_owner;
                bus.d_gnt        = r_owner;
                if (r_k == r_last_k) begin
                    w_next = r_we ? ST_DONE : ST_RTAIL;
                end
            end
            ST_RTAIL: begin
                bus.c_gnt = ~r_owner;
                bus.d_gnt = r_owner;
                w_next    = ST_DONE;
            end
            ST_DONE: begin
                bus.c_gnt  = ~r_owner;
                bus.d_gnt  = r_owner;
                bus.c_done = ~r_owner;
                bus.d_done = r_owner;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= 1'b0;
            r_last_d  <= 1'b1;
            r_we      <= 1'b0;
            r_base    <= '0;
            r_last_k  <= 2'd0;
            r_k       <= 2'd0;
            r_wdata   <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_rd_pend <= 1'b0;
            r_rd_idx  <= 2'd0;
        end else begin
            r_rd_pend <= 1'b0;
            // Memory answers one cycle after the address, so land the nibble
            // issued on the previous cycle.
            if (r_rd_pend) begin
                r_rdata[{r_rd_idx, 2'b00} +: 4] <= bus.mem_data_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_pick_d;
                        r_we     <= w_sel_we;
                        r_base   <= w_sel_addr;
                        r_last_k <= f_last_k(w_sel_len);
                        r_wdata  <= w_sel_wdata;
                        r_k      <= 2'd0;
                        if (!w_sel_we) begin
                            r_rdata <= 16'h0000;
                        end
                    end
                end
                ST_XFER: begin
                    r_k       <= r_k + 2'd1;
                    r_rd_pend <= ~r_we;
                    r_rd_idx  <= r_k;
                end
                ST_DONE: begin
                    r_last_d <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_misao_mem_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_misao_mem_arb
// Brief    : Directed scoreboard bench for misao_mem_arb with a nibble memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_misao_mem_arb;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [3:0]  data;
    } mem_ev_t;

    typedef struct {
        logic        dbg;
        logic [15:0] rdata;
    } done_ev_t;

    logic clk;
    logic rst_n;
    logic [3:0] rd_q;
    logic [3:0] mem [0:65535];

    int total;
    int bad;
    int done_seen;
    logic [15:0] model_rdata;

    mem_ev_t  exp_mem[$];
    done_ev_t exp_done[$];

    misao_mem_arb_if #(.ADDR_W(16)) bus ();

    misao_mem_arb #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle latency nibble memory
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_rw) mem[bus.mem_addr] <= bus.mem_data_out;
        if (bus.mem_en && bus.mem_rw)  rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_data_in = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: pops when the DUT issues a memory cycle or completes
    always @(negedge clk) begin
        if (rst_n) begin
            mem_ev_t  me;
            done_ev_t de;
            chk("gnt_excl", {31'b0, bus.c_gnt & bus.d_gnt}, 32'd0);
            if (bus.mem_en) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    me = exp_mem.pop_front();
                    chk("mem_addr", {16'b0, bus.mem_addr}, {16'b0, me.addr});
                    chk("mem_rw", {31'b0, bus.mem_rw}, {31'b0, me.rw});
                    chk("mem_data_out", {28'b0, bus.mem_data_out}, {28'b0, me.data});
                end
            end
            if (bus.c_done || bus.d_done) begin
                done_seen++;
                chk("done_excl", {31'b0, bus.c_done & bus.d_done}, 32'd0);
                chk("done_owner_gnt", {31'b0, bus.d_done ? bus.d_gnt : bus.c_gnt}, 32'd1);
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    de = exp_done.pop_front();
                    chk("done_owner", {31'b0, bus.d_done}, {31'b0, de.dbg});
                    chk("done_rdata", {16'b0, bus.rdata}, {16'b0, de.rdata});
                end
            end
        end
    end

    function automatic int nib_count(input logic [1:0] len);
        return (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 1;
    endfunction

    task automatic push_expect(input logic dbg, input logic we, input logic [15:0] addr,
                               input logic [1:0] len, input logic [15:0] wdata,
                               input logic [15:0] rd_exp);
        mem_ev_t  me;
        done_ev_t de;
        logic [15:0] w;
        for (int k = 0; k < nib_count(len); k++) begin
            w       = wdata >> (4 * k);
            me.addr = addr + 16'(k);
            me.rw   = ~we;
            me.data = we ? w[3:0] : 4'h0;
            exp_mem.push_back(me);
        end
        if (!we) model_rdata = rd_exp;
        de.dbg   = dbg;
        de.rdata = model_rdata;
        exp_done.push_back(de);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic do_xfer(input string tag, input logic dbg, input logic we,
                           input logic [15:0] addr, input logic [1:0] len,
                           input logic [15:0] wdata, input logic [15:0] rd_exp);
        int cyc;
        int lat;
        bit seen;
        push_expect(dbg, we, addr, len, wdata, rd_exp);
        lat = nib_count(len) + (we ? 1 : 2);
        if (dbg) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_len = len; bus.d_wdata = wdata;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_len = len; bus.c_wdata = wdata;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_gnt"}, {30'b0, bus.d_gnt, bus.c_gnt}, dbg ? 32'd2 : 32'd1);
                bus.c_req = 1'b0;
                bus.d_req = 1'b0;
            end
            if (bus.c_done || bus.d_done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; done_seen = 0;
        model_rdata = 16'h0000;
        rst_n = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 16'h0; bus.c_len = 2'b00; bus.c_wdata = 16'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_len = 2'b00; bus.d_wdata = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 4'h0;
        mem[16'h0020] = 4'h3; mem[16'h0021] = 4'hA;
        mem[16'hFFFE] = 4'h1; mem[16'hFFFF] = 4'h2;
        mem[16'h0000] = 4'h3; mem[16'h0001] = 4'h4;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {24'b0, bus.c_gnt, bus.d_gnt, bus.c_done, bus.d_done, bus.mem_en, bus.mem_rw, 2'b0},
            32'h0000_0004);
        chk("rst_rdata", {16'b0, bus.rdata}, 32'd0);
        chk("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests from reset: core, debug, core, debug
        push_expect(1'b0, 1'b1, 16'h0300, 2'b00, 16'h0001, 16'h0);
        push_expect(1'b1, 1'b1, 16'h0301, 2'b00, 16'h0002, 16'h0);
        push_expect(1'b0, 1'b1, 16'h0300, 2'b00, 16'h0001, 16'h0);
        push_expect(1'b1, 1'b1, 16'h0301, 2'b00, 16'h0002, 16'h0);
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 16'h0300; bus.c_len = 2'b00; bus.c_wdata = 16'h0001;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0301; bus.d_len = 2'b00; bus.d_wdata = 16'h0002;
        for (int i = 0; i < 40 && done_seen < 4; i++) begin
            @(posedge clk);
            #1;
        end
        chk("tie_done_count", 32'(done_seen), 32'd4);
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tie_mem", {24'b0, mem[16'h0300], mem[16'h0301]}, 32'h12);

        do_xfer("c_wr16", 1'b0, 1'b1, 16'h0100, 2'b10, 16'hBEEF, 16'h0);
        chk("c_wr16_mem", {16'b0, mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]},
            32'h0000_BEEF);

        do_xfer("d_rd8", 1'b1, 1'b0, 16'h0020, 2'b01, 16'h0, 16'h00A3);
        do_xfer("c_rd_wrap", 1'b0, 1'b0, 16'hFFFE, 2'b10, 16'h0, 16'h4321);
        do_xfer("d_wr8", 1'b1, 1'b1, 16'h0600, 2'b01, 16'h00C5, 16'h0);
        chk("d_wr8_mem", {24'b0, mem[16'h0601], mem[16'h0600]}, 32'hC5);
        chk("wr_keeps_rdata", {16'b0, bus.rdata}, 32'h4321);
        do_xfer("d_rd_len11", 1'b1, 1'b0, 16'h0021, 2'b11, 16'h0, 16'h000A);
        do_xfer("c_rd_drop", 1'b0, 1'b0, 16'h0020, 2'b01, 16'h0, 16'h00A3);
        repeat (3) begin
            @(negedge clk);
            chk("no_regrant", {30'b0, bus.c_gnt, bus.d_gnt}, 32'd0);
        end

        // Reset during the second cycle of a 4-nibble write
        push_expect(1'b0, 1'b1, 16'h0400, 2'b00, 16'h0004, 16'h0);
        void'(exp_done.pop_back());
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 16'h0400; bus.c_len = 2'b10; bus.c_wdata = 16'h1234;
        @(posedge clk);
        #1;
        bus.c_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {24'b0, bus.c_gnt, bus.d_gnt, bus.c_done, bus.d_done, bus.mem_en, bus.mem_rw, 2'b0},
            32'h0000_0004);
        chk("mid_rst_addr_data", {12'b0, bus.mem_addr, bus.mem_data_out}, 32'd0);
        chk("mid_rst_rdata", {16'b0, bus.rdata}, 32'd0);
        model_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_partial", {24'b0, mem[16'h0401], mem[16'h0400]}, 32'h04);
        @(negedge clk);
        do_xfer("post_rst_wr", 1'b0, 1'b1, 16'h0500, 2'b00, 16'h0007, 16'h0);
        chk("post_rst_mem", {28'b0, mem[16'h0500]}, 32'h7);

        repeat (2) @(negedge clk);
        chk("sb_mem_empty", 32'(exp_mem.size()), 32'd0);
        chk("sb_done_empty", 32'(exp_done.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/misao_mem_arb.md
MISAO_MEM_ARB -- requirements
Module: misao_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports c_req/d_req, input, 1 each, transfer requests from core (c) and debug loader (d).
REQ-005 SHALL have ports c_we/d_we, input, 1 each; 1=write, 0=read.
REQ-006 SHALL have ports c_addr/d_addr, input, ADDR_W each, base nibble address.
REQ-007 SHALL have ports c_len/d_len, input, 2 each; 00=1 nibble (UL), 01=2 (LK8), 10=4 (LK16), 11=1 nibble.
REQ-008 SHALL have ports c_wdata/d_wdata, input, 16 each, write data; nibble k = bits [4k+3:4k].
REQ-009 SHALL have ports c_gnt/d_gnt, output, 1 each, high while that requester owns the port.
REQ-010 SHALL have ports c_done/d_done, output, 1 each, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 16, assembled read data shared by both requesters.
REQ-012 SHALL have ports mem_en, output, 1; mem_rw, output, 1 (1=read, 0=write); mem_addr, output, ADDR_W; mem_data_out, output, 4; mem_data_in, input, 4.

Function
REQ-013 SHALL implement FSM states IDLE, XFER, RTAIL, DONE.
REQ-014 IDLE: if any req high, SHALL latch winner's we/addr/len/wdata, assert its gnt next cycle, go to XFER with nibble counter k=0.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests, winner is the requester not granted last; after reset, core wins first tie.
REQ-016 Single request SHALL be granted regardless of round-robin history.
REQ-017 XFER: SHALL drive mem_en=1, mem_addr=base+k (modulo 2^ADDR_W, 0xFFFF wraps to 0x0000), mem_rw=!we, mem_data_out=wdata nibble k (0 when reading); k increments each cycle.
REQ-018 XFER with N nibbles SHALL last exactly N cycles; after last nibble, write goes to DONE, read goes to RTAIL.
REQ-019 Memory read latency is one cycle: nibble issued at cycle t SHALL be captured from mem_data_in at edge ending cycle t+1 into rdata bits [4k+3:4k].
REQ-020 RTAIL SHALL last one cycle with mem_en=0, capturing final nibble.
REQ-021 At read start rdata SHALL clear to 0; unread upper nibbles stay 0 (zero-extension).
REQ-022 rdata SHALL hold its value from DONE until the next read transfer begins; writes SHALL NOT change rdata.
REQ-023 DONE: SHALL pulse owner's done for one cycle, deassert gnt, update round-robin pointer, return to IDLE.
REQ-024 Latency from req sampled in IDLE to done: write N+1 cycles, read N+2 cycles; min gap between transfers is one IDLE cycle.
REQ-025 Request inputs SHALL be ignored outside IDLE; deasserting req mid-transfer SHALL NOT abort it.
REQ-026 gnt outputs SHALL be mutually exclusive; done SHALL only pulse for the current owner.
REQ-027 Outside XFER, mem_en=0, mem_rw=1, mem_addr=0, mem_data_out=0.

Reset
REQ-028 rst low SHALL immediately force IDLE, all gnt/done=0, rdata=0, mem_en=0, mem_rw=1, mem_addr=0, mem_data_out=0, round-robin pointer to core-first.
REQ-029 Reset mid-transfer SHALL abort it with no done pulse; partially written nibbles remain in memory.
REQ-030 After rst rises, first arbitration SHALL occur on first clk edge in IDLE.

Verification
REQ-031 Core write len=10, addr=0x0100, wdata=0xBEEF -> 4 XFER cycles writing F,E,E,B to 0x0100..0x0103, c_done at cycle 5.
REQ-032 Debug read len=01, addr=0x0020, memory 0x0020=3, 0x0021=A -> rdata=0x00A3 with d_done at cycle 4.
REQ-033 c_req and d_req high together from reset, each len=00 -> order core, debug, core, debug; gnts never overlap.
REQ-034 Core read len=10, addr=0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 rst low during cycle 2 of a 4-nibble write -> all outputs at reset values immediately, no c_done, next request served normally.
REQ-036 c_req dropped after grant during a len=01 read -> transfer completes, c_done pulses, no new grant.
